// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the bit serializer.
interface bit_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              ser_valid;
  logic              ser_bit;
  logic              word_done;
  logic              busy;

  modport master (
    output in_data, in_valid, flush,
    input  in_ready, ser_valid, ser_bit, word_done, busy
  );

  modport slave (
    input  in_data, in_valid, flush,
    output in_ready, ser_valid, ser_bit, word_done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: first bit one cycle after acceptance, one bit per clock.
// A one-word hold buffer keeps back-to-back words gapless; in_ready drops only while it is full.
module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  bit_serializer_if.slave bus
);
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_full_q, hold_full_d;

  logic accept;
  logic last_bit;
  logic out_bit;

  assign bus.in_ready = !hold_full_q && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_bit     = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign out_bit      = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1];

  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_bit   = (state_q == SHIFT) && out_bit;
  assign bus.word_done = last_bit;
  assign bus.busy      = (state_q == SHIFT) || hold_full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;

    if (bus.flush) begin
      // Abort wins over everything; in_ready is already low so nothing is accepted.
      state_d     = IDLE;
      hold_full_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d = bus.in_data;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            cnt_d = '0;
            if (hold_full_q) begin
              shreg_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              shreg_d = bus.in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + CNT_W'(1);
            if (accept) begin
              hold_d      = bus.in_data;
              hold_full_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bit_serializer_if #(.DATA_W(8)) bus_m ();
  bit_serializer_if #(.DATA_W(8)) bus_l ();

  bit_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));
  bit_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] want4;
  logic [4:0] want5;

  function automatic void push_word(input logic [7:0] w, input bit lsb);
    for (int k = 0; k < 8; k++) begin
      exp_t x;
      x.b    = lsb ? w[k] : w[7-k];
      x.last = (k == 7);
      sb.push_back(x);
    end
  endfunction

  // Expected {ser_valid, ser_bit, word_done, busy} for this cycle, popped from the scoreboard.
  function automatic logic [3:0] next_exp();
    exp_t x;
    if (sb.size() == 0) return 4'b0000;
    x = sb.pop_front();
    return {1'b1, x.b, x.last, 1'b1};
  endfunction

  task automatic test_reset();
    bus_m.in_data = '0; bus_m.in_valid = 1'b0; bus_m.flush = 1'b0;
    bus_l.in_data = '0; bus_l.in_valid = 1'b0; bus_l.flush = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_idle: got %b want 00001", {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready});
    end
  endtask

  task automatic test_single();
    bus_m.in_data = 8'hB6; bus_m.in_valid = 1'b1;
    push_word(8'hB6, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      want4 = next_exp();
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy} !== want4) begin
        bad++;
        $display("FAIL single cyc%0d: got %b want %b", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy}, want4);
      end
      bus_m.in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bus_m.in_data = 8'hB6; bus_m.in_valid = 1'b1;
    push_word(8'hB6, 1'b0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      want4 = next_exp();
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy} !== want4) begin
        bad++;
        $display("FAIL b2b cyc%0d: got %b want %b", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy}, want4);
      end
      total++;
      if (bus_m.in_ready !== ((i >= 1 && i <= 7) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL b2b_in_ready cyc%0d: got %b want %b", i, bus_m.in_ready, (i >= 1 && i <= 7) ? 1'b0 : 1'b1);
      end
      if (i == 0) begin
        bus_m.in_data = 8'hDB;
        push_word(8'hDB, 1'b0);
      end else begin
        bus_m.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_bypass();
    bus_m.in_data = 8'hB6; bus_m.in_valid = 1'b1;
    push_word(8'hB6, 1'b0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      want4 = next_exp();
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy} !== want4) begin
        bad++;
        $display("FAIL bypass cyc%0d: got %b want %b", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy}, want4);
      end
      total++;
      if (bus_m.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL bypass_in_ready cyc%0d: got %b want 1", i, bus_m.in_ready);
      end
      bus_m.in_valid = (i == 7);
      if (i == 7) begin
        bus_m.in_data = 8'hDB;
        push_word(8'hDB, 1'b0);
      end
    end
  endtask

  task automatic test_lsb_first();
    bus_l.in_data = 8'h01; bus_l.in_valid = 1'b1;
    push_word(8'h01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      want4 = next_exp();
      total++;
      if ({bus_l.ser_valid, bus_l.ser_bit, bus_l.word_done, bus_l.busy} !== want4) begin
        bad++;
        $display("FAIL lsb_first cyc%0d: got %b want %b", i, {bus_l.ser_valid, bus_l.ser_bit, bus_l.word_done, bus_l.busy}, want4);
      end
      bus_l.in_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    bus_m.in_data = 8'hFF; bus_m.in_valid = 1'b1;
    push_word(8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      want4 = next_exp();
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy} !== want4) begin
        bad++;
        $display("FAIL rst_pre cyc%0d: got %b want %b", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy}, want4);
      end
      bus_m.in_valid = 1'b0;
    end
    // Mid-cycle, well clear of the next rising edge.
    #2 reset = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL rst_async: got %b want 00001", {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready} !== 5'b00001) begin
        bad++;
        $display("FAIL rst_post cyc%0d: got %b want 00001", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready});
      end
    end
  endtask

  task automatic test_flush();
    bus_m.in_data = 8'hB6; bus_m.in_valid = 1'b1;
    push_word(8'hB6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      want4 = next_exp();
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy} !== want4) begin
        bad++;
        $display("FAIL flush_pre cyc%0d: got %b want %b", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy}, want4);
      end
      if (i == 0) begin
        bus_m.in_data = 8'hDB;
        push_word(8'hDB, 1'b0);
      end else begin
        bus_m.in_valid = 1'b0;
      end
    end
    bus_m.flush = 1'b1; bus_m.in_valid = 1'b1; bus_m.in_data = 8'hFF;
    #1;
    total++;
    if (bus_m.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_ready: got %b want 0", bus_m.in_ready);
    end
    @(negedge clk);
    bus_m.flush = 1'b0; bus_m.in_valid = 1'b0;
    sb.delete();
    #1;
    want5 = 5'b00001;
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready} !== want5) begin
        bad++;
        $display("FAIL flush_post cyc%0d: got %b want %b", i, {bus_m.ser_valid, bus_m.ser_bit, bus_m.word_done, bus_m.busy, bus_m.in_ready}, want5);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_lsb_first();
    test_async_reset();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end that feeds the sequence detector: accepts DATA_W-bit words over a valid/ready handshake and emits one bit per clock.
- Output pair ser_valid/ser_bit connects directly to the detector's valid/bit_in inputs.
- A one-word holding buffer lets back-to-back words stream with no idle gap between them.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  DATA_W  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort; discards the current and held words.
- ser_valid  output  1  ser_bit is valid; drives the detector's valid input.
- ser_bit  output  1  serial data bit; drives the detector's bit_in input.
- word_done  output  1  one-cycle pulse while the last bit of a word is on ser_bit.
- busy  output  1  high when the serializer is in SHIFT or the hold register is full.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE, shift register 0, bit counter 0, hold empty;
  - ser_valid=0, ser_bit=0, word_done=0, busy=0, in_ready=1.
  - Reset mid-word truncates the word; no further bits are output.
- Handshake:
  - in_ready = !hold_full && !flush.
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_data is sampled only at acceptance.
- Outputs are register-derived; there is no combinational path from any input to ser_valid, ser_bit or word_done.
  - ser_valid = (state==SHIFT).
  - ser_bit = current bit of the shift register when ser_valid=1, else 0.
  - word_done = ser_valid && (bit counter == DATA_W-1).
- FSM states: IDLE, SHIFT.
  - IDLE: on acceptance at edge N, load the word into the shift register (hold is bypassed), counter=0, go to SHIFT. Latency: first bit is visible during the cycle after edge N.
  - SHIFT, non-final edge: shift one position toward the output end; counter+1.
  - SHIFT, final edge (counter==DATA_W-1):
    - If the hold is full: move the hold into the shift register, empty the hold, counter=0, stay in SHIFT. No gap in ser_valid.
    - Else if a word is accepted on this same edge: bypass it straight into the shift register, counter=0, stay in SHIFT. No gap.
    - Else: go to IDLE; ser_valid drops.
  - SHIFT, acceptance on a non-final edge: the word goes into the hold; hold_full=1, so in_ready=0 next cycle.
- Capacity: at most 2 words in flight (shifting + held). in_ready re-asserts the cycle after the hold drains.
- Bit order: the transmitted word is in_data[DATA_W-1]..in_data[0] when LSB_FIRST=0, and in_data[0]..in_data[DATA_W-1] when LSB_FIRST=1.
- Counter width: clog2(DATA_W); it wraps only via reload at counter==DATA_W-1.
- flush=1 at an edge:
  - state goes to IDLE, hold is emptied, counter=0;
  - no word is accepted, since in_ready=0 while flush=1;
  - flush has priority over every other event.
- busy = (state==SHIFT) || hold_full.

Test Plan:
- After reset release, check idle outputs: ser_valid=0, ser_bit=0, in_ready=1, busy=0. Then send 0xB6 once with DATA_W=8, LSB_FIRST=0. Required:
  - ser_valid=1 for exactly 8 cycles starting the cycle after acceptance;
  - ser_bit = 1,0,1,1,0,1,1,0;
  - word_done high only on the 8th bit;
  - ser_valid=0 afterwards.
- Back-to-back: present 0xB6 then 0xDB with in_valid held high. Required:
  - ser_valid high for 16 contiguous cycles, bits 1011011011011011;
  - in_ready=0 from the cycle after the second accept until the cycle after the first word's final edge;
  - word_done pulses on cycles 8 and 16.
- Bypass on final edge: second word asserted only on the first word's final edge. Required: 16 contiguous bits with no gap, and the hold is never filled (in_ready stays 1).
- LSB_FIRST=1: send 0x01. Required: ser_bit = 1,0,0,0,0,0,0,0.
- Reset asserted asynchronously during bit 4 of 0xFF. Required:
  - ser_valid and ser_bit go to 0 immediately, without waiting for a clock edge;
  - after release, in_ready=1 and no residual bits are output.
- flush with one word shifting and one held. Required:
  - next cycle ser_valid=0, busy=0, in_ready=1;
  - a word presented with in_valid during the flush cycle is not accepted.
